// File: rtl/instr_fetch.sv
// Instruction fetch stage: word-addressed PC, one-cycle synchronous fetch into the
// IF/ID register, with stall, branch redirect and a RUN/HALTED state machine.
module instr_fetch #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_tgt,
    output logic [15:0] im_addr,
    output logic        im_rd_en,
    input  logic [15:0] im_instr,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc_plus1,
    output logic        if_valid,
    output logic        halted
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state_r;
    logic [15:0] pc_r;
    logic [15:0] if_instr_r;
    logic [15:0] if_pc_plus1_r;
    logic        if_valid_r;
    logic        halted_r;
    logic        fetch_s;

    function automatic logic is_halt(input logic [15:0] instr);
        return (instr[15:12] == HLT_OPCODE);
    endfunction

    // Wraps naturally at 16 bits: 16'hFFFF advances to 16'h0000.
    function automatic logic [15:0] pc_inc(input logic [15:0] pc);
        return pc + 16'h0001;
    endfunction

    // A real fetch happens only when running, out of reset, unstalled and not redirected.
    always_comb begin
        fetch_s = 1'b0;
        if (rst_n && (state_r == RUN) && !stall && !branch_taken) begin
            fetch_s = 1'b1;
        end else begin
            fetch_s = 1'b0;
        end
    end

    assign im_addr     = pc_r;
    assign im_rd_en    = fetch_s;
    assign if_instr    = if_instr_r;
    assign if_pc_plus1 = if_pc_plus1_r;
    assign if_valid    = if_valid_r;
    assign halted      = halted_r;

    // PC, IF/ID register and fetch state machine; branch beats stall, reset beats all.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= RUN;
            pc_r          <= RESET_PC;
            if_instr_r    <= NOP_INSTR;
            if_pc_plus1_r <= 16'h0000;
            if_valid_r    <= 1'b0;
            halted_r      <= 1'b0;
        end else if (branch_taken) begin
            // Redirect also cancels a halt fetched in the branch shadow.
            state_r    <= RUN;
            pc_r       <= branch_tgt;
            if_instr_r <= NOP_INSTR;
            if_valid_r <= 1'b0;
            halted_r   <= 1'b0;
        end else if (stall) begin
            state_r <= state_r;
        end else begin
            case (state_r)
                RUN: begin
                    pc_r          <= pc_inc(pc_r);
                    if_instr_r    <= im_instr;
                    if_pc_plus1_r <= pc_inc(pc_r);
                    if_valid_r    <= 1'b1;
                    if (is_halt(im_instr)) begin
                        state_r  <= HALTED;
                        halted_r <= 1'b1;
                    end else begin
                        state_r  <= RUN;
                        halted_r <= 1'b0;
                    end
                end
                HALTED: begin
                    if_instr_r <= NOP_INSTR;
                    if_valid_r <= 1'b0;
                    halted_r   <= 1'b1;
                end
                default: begin
                    state_r    <= RUN;
                    if_instr_r <= NOP_INSTR;
                    if_valid_r <= 1'b0;
                    halted_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a behavioural fetch model queues the expected
// IF/ID contents per cycle; directed constant checks cover the key scenarios.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n, stall, branch_taken;
    logic [15:0] branch_tgt;
    logic [15:0] im_addr, im_instr, if_instr, if_pc_plus1;
    logic        im_rd_en, if_valid, halted;

    logic        rst2_n;
    logic        stall2 = 1'b0;
    logic        branch2 = 1'b0;
    logic [15:0] tgt2 = 16'h0000;
    logic [15:0] im_addr2, im_instr2, if_instr2, if_pc_plus1_2;
    logic        im_rd_en2, if_valid2, halted2;

    logic [15:0] mem [0:65535];

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pp1;
        logic [15:0] pc;
        logic        valid;
        logic        halt;
    } exp_t;

    exp_t        sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    logic [15:0] m_pc, m_instr, m_pp1;
    logic        m_valid, m_halt;
    logic        m_init = 1'b0;

    always #5 clk = ~clk;

    assign im_instr  = mem[im_addr];
    assign im_instr2 = mem[im_addr2];

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_tgt(branch_tgt), .im_addr(im_addr), .im_rd_en(im_rd_en),
        .im_instr(im_instr), .if_instr(if_instr), .if_pc_plus1(if_pc_plus1),
        .if_valid(if_valid), .halted(halted)
    );

    instr_fetch #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst_n(rst2_n), .stall(stall2), .branch_taken(branch2),
        .branch_tgt(tgt2), .im_addr(im_addr2), .im_rd_en(im_rd_en2),
        .im_instr(im_instr2), .if_instr(if_instr2), .if_pc_plus1(if_pc_plus1_2),
        .if_valid(if_valid2), .halted(halted2)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check combinational outputs, queue expectation, check after edge.
    task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t);
        exp_t e;
        rst_n = r; stall = s; branch_taken = b; branch_tgt = t;
        #1;
        chk("im_rd_en", {15'h0000, im_rd_en}, {15'h0000, (r && m_init && !m_halt && !s && !b)});
        if (m_init) chk("im_addr", im_addr, m_pc);
        if (!r) begin
            m_pc = 16'h0000; m_halt = 1'b0; m_valid = 1'b0;
            m_instr = 16'h0000; m_pp1 = 16'h0000; m_init = 1'b1;
        end else if (b) begin
            m_pc = t; m_valid = 1'b0; m_instr = 16'h0000; m_halt = 1'b0;
        end else if (s) begin
            m_pc = m_pc;
        end else if (!m_halt) begin
            m_instr = mem[m_pc];
            m_pp1   = m_pc + 16'h0001;
            m_valid = 1'b1;
            m_halt  = (m_instr[15:12] == 4'hF);
            m_pc    = m_pc + 16'h0001;
        end else begin
            m_valid = 1'b0; m_instr = 16'h0000;
        end
        sb_q.push_back('{instr: m_instr, pp1: m_pp1, pc: m_pc, valid: m_valid, halt: m_halt});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (m_init) begin
            chk("sb_if_instr", if_instr, e.instr);
            chk("sb_if_pc_plus1", if_pc_plus1, e.pp1);
            chk("sb_if_valid", {15'h0000, if_valid}, {15'h0000, e.valid});
            chk("sb_halted", {15'h0000, halted}, {15'h0000, e.halt});
            chk("sb_pc", im_addr, e.pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = {4'h1, i[11:0]};
        end
        mem[16'h0000] = 16'h1111;
        mem[16'h0001] = 16'h2222;
        mem[16'h0002] = 16'h3333;
        mem[16'h0003] = 16'hF000;
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_tgt = 16'h0000;
        rst2_n = 1'b0;
        m_pc = 16'h0000; m_instr = 16'h0000; m_pp1 = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
        @(posedge clk);
        #1;

        // Reset, including reset overriding stall and branch
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 16'h0040);
        chk("rst_valid", {15'h0000, if_valid}, 16'h0000);
        chk("rst_instr", if_instr, 16'h0000);
        chk("rst_pp1", if_pc_plus1, 16'h0000);
        chk("rst_halted", {15'h0000, halted}, 16'h0000);
        chk("rst_addr", im_addr, 16'h0000);
        chk("rst_rden", {15'h0000, im_rd_en}, 16'h0000);

        // Sequential fetch and a two-cycle stall
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("seq0_instr", if_instr, 16'h1111);
        chk("seq0_pp1", if_pc_plus1, 16'h0001);
        chk("seq0_valid", {15'h0000, if_valid}, 16'h0001);
        step(1'b1, 1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 1'b0, 16'h0000);
        chk("stall_instr", if_instr, 16'h1111);
        chk("stall_addr", im_addr, 16'h0001);
        chk("stall_rden", {15'h0000, im_rd_en}, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("seq1_instr", if_instr, 16'h2222);
        chk("seq1_pp1", if_pc_plus1, 16'h0002);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("seq2_instr", if_instr, 16'h3333);
        chk("seq2_pp1", if_pc_plus1, 16'h0003);

        // Halt, held under stall, then bubbles
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("halt_instr", if_instr, 16'hF000);
        chk("halt_valid", {15'h0000, if_valid}, 16'h0001);
        chk("halt_flag", {15'h0000, halted}, 16'h0001);
        chk("halt_addr", im_addr, 16'h0004);
        step(1'b1, 1'b1, 1'b0, 16'h0000);
        chk("halt_stall_instr", if_instr, 16'hF000);
        chk("halt_stall_valid", {15'h0000, if_valid}, 16'h0001);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0000);
        end
        chk("halted_valid", {15'h0000, if_valid}, 16'h0000);
        chk("halted_instr", if_instr, 16'h0000);
        chk("halted_addr", im_addr, 16'h0004);
        chk("halted_rden", {15'h0000, im_rd_en}, 16'h0000);

        // Halt cancel by branch
        step(1'b1, 1'b0, 1'b1, 16'h0010);
        chk("cancel_halted", {15'h0000, halted}, 16'h0000);
        chk("cancel_addr", im_addr, 16'h0010);
        chk("cancel_valid", {15'h0000, if_valid}, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("resume_instr", if_instr, 16'h1010);
        chk("resume_pp1", if_pc_plus1, 16'h0011);

        // Branch wins over stall
        step(1'b1, 1'b1, 1'b1, 16'h0040);
        chk("bs_valid", {15'h0000, if_valid}, 16'h0000);
        chk("bs_instr", if_instr, 16'h0000);
        chk("bs_addr", im_addr, 16'h0040);
        chk("bs_pp1_hold", if_pc_plus1, 16'h0011);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("bs_fetch", if_instr, 16'h1040);

        // Random mix of stall, branch and reset
        for (int k = 0; k < 80; k++) begin
            step(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) == 0), 16'($urandom_range(0, 8)));
        end

        // Reset while halted
        step(1'b1, 1'b0, 1'b1, 16'h0003);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("pre_rst_halted", {15'h0000, halted}, 16'h0001);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("hrst_halted", {15'h0000, halted}, 16'h0000);
        chk("hrst_valid", {15'h0000, if_valid}, 16'h0000);
        chk("hrst_pp1", if_pc_plus1, 16'h0000);
        chk("hrst_addr", im_addr, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        chk("hrst_fetch", if_instr, 16'h1111);

        // Wrap-around with RESET_PC = 16'hFFFF
        rst2_n = 1'b1;
        #1;
        chk("wrap_addr0", im_addr2, 16'hFFFF);
        chk("wrap_rden", {15'h0000, im_rd_en2}, 16'h0001);
        @(posedge clk);
        #1;
        chk("wrap_pp1", if_pc_plus1_2, 16'h0000);
        chk("wrap_instr", if_instr2, 16'h1FFF);
        chk("wrap_addr1", im_addr2, 16'h0000);
        @(posedge clk);
        #1;
        chk("wrap_instr2", if_instr2, 16'h1111);
        chk("wrap_pp1_2", if_pc_plus1_2, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
